// File: rtl/pr_pkg.sv
// Shared types and constants for the P-R register file access sequencer.
package pr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ACK
    } pr_state_e;

    localparam logic [2:0] REG_R0 = 3'd0;
    localparam int         CNT_W  = 3;

    // Phase counters run from LEN-1 down to 0.
    function automatic logic [CNT_W-1:0] len_m1(input int len);
        return CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/pr_rr_arb.sv
// Two-way round-robin arbiter: control unit (A) vs control panel (B).
module pr_rr_arb (
    input  logic clk_i,
    input  logic clm_i,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic take_i,
    input  logic done_i,
    output logic vld_o,
    output logic pick_b_o,
    output logic gnt_b_o
);

    logic gnt_b_q;
    logic prio_b_q;

    // prio_b_q=1 means B wins the next tie; it flips away from whoever finished last.
    assign vld_o    = req_a_i | req_b_i;
    assign pick_b_o = req_b_i & (~req_a_i | prio_b_q);
    assign gnt_b_o  = gnt_b_q;

    always_ff @(posedge clk_i) begin
        if (!clm_i) begin
            gnt_b_q  <= 1'b0;
            prio_b_q <= 1'b0;
        end else begin
            if (take_i) gnt_b_q <= pick_b_o;
            if (done_i) prio_b_q <= ~gnt_b_q;
        end
    end

endmodule

// File: rtl/pr_access_seq.sv
// Sequences setup/strobe/hold accesses to the P-R register file for two requesters.
module pr_access_seq
    import pr_pkg::*;
#(
    parameter int SETUP_LEN = 1,
    parameter int STB_LEN   = 2,
    parameter int HOLD_LEN  = 1
) (
    input  logic        __clk,
    input  logic        clm_,
    input  logic        a_req,
    input  logic        a_wr,
    input  logic        a_ph2,
    input  logic [2:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    input  logic        b_req,
    input  logic        b_wr,
    input  logic        b_ph2,
    input  logic [2:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] rdata,
    input  logic [15:0] l,
    output logic [15:0] w,
    output logic        ra,
    output logic        rb,
    output logic        rc,
    output logic        w_r,
    output logic        as2,
    output logic        strob1,
    output logic        strob2,
    output logic        busy
);

    pr_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       addr_q;
    logic [15:0]      w_q;
    logic [15:0]      rdata_q;
    logic             w_r_q, as2_q, s1_q, s2_q, a_ack_q, b_ack_q;

    logic        vld, pick_b, gnt_b, take;
    logic        sel_wr, sel_ph2;
    logic [2:0]  sel_addr;
    logic [15:0] sel_wdata;

    assign take = (state_q == IDLE) && vld;

    pr_rr_arb u_arb (
        .clk_i    (__clk),
        .clm_i    (clm_),
        .req_a_i  (a_req),
        .req_b_i  (b_req),
        .take_i   (take),
        .done_i   (state_q == ACK),
        .vld_o    (vld),
        .pick_b_o (pick_b),
        .gnt_b_o  (gnt_b)
    );

    assign sel_wr    = pick_b ? b_wr    : a_wr;
    assign sel_ph2   = pick_b ? b_ph2   : a_ph2;
    assign sel_addr  = pick_b ? b_addr  : a_addr;
    assign sel_wdata = pick_b ? b_wdata : a_wdata;

    always_ff @(posedge __clk) begin
        if (!clm_) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= REG_R0;
            w_q     <= '0;
            rdata_q <= '0;
            w_r_q   <= 1'b0;
            as2_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: if (take) begin
                    addr_q  <= sel_addr;
                    w_q     <= sel_wr ? sel_wdata : 16'h0000;
                    w_r_q   <= sel_wr;
                    as2_q   <= sel_ph2;
                    cnt_q   <= len_m1(SETUP_LEN);
                    state_q <= SETUP;
                end
                SETUP: if (cnt_q == '0) begin
                    s1_q    <= ~as2_q;
                    s2_q    <= as2_q;
                    cnt_q   <= len_m1(STB_LEN);
                    state_q <= STROBE;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                STROBE: if (cnt_q == '0) begin
                    s1_q    <= 1'b0;
                    s2_q    <= 1'b0;
                    cnt_q   <= len_m1(HOLD_LEN);
                    state_q <= HOLD;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                HOLD: if (cnt_q == '0) begin
                    // L bus is sampled on the final hold cycle, before the bus is released.
                    if (!w_r_q) rdata_q <= l;
                    addr_q  <= REG_R0;
                    w_q     <= '0;
                    w_r_q   <= 1'b0;
                    as2_q   <= 1'b0;
                    a_ack_q <= ~gnt_b;
                    b_ack_q <= gnt_b;
                    state_q <= ACK;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {rc, rb, ra} = addr_q;
    assign w      = w_q;
    assign w_r    = w_r_q;
    assign as2    = as2_q;
    assign strob1 = s1_q;
    assign strob2 = s2_q;
    assign a_ack  = a_ack_q;
    assign b_ack  = b_ack_q;
    assign rdata  = rdata_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_pr_access_seq.sv
// Directed bench for pr_access_seq: default timing plus a 3/4/3 timing build.
module tb_pr_access_seq;

    logic        clk = 1'b0;
    logic        clm_;
    logic        a_req, a_wr, a_ph2, b_req, b_wr, b_ph2;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata, l;

    logic        a_ack, b_ack, ra, rb, rc, w_r, as2, strob1, strob2, busy;
    logic [15:0] rdata, w;
    logic        a_ack2, b_ack2, ra2, rb2, rc2, w_r2, as22, s12, s22, busy2;
    logic [15:0] rdata2, w2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pr_access_seq dut (
        .__clk(clk), .clm_(clm_),
        .a_req(a_req), .a_wr(a_wr), .a_ph2(a_ph2), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
        .b_req(b_req), .b_wr(b_wr), .b_ph2(b_ph2), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
        .rdata(rdata), .l(l), .w(w), .ra(ra), .rb(rb), .rc(rc), .w_r(w_r), .as2(as2),
        .strob1(strob1), .strob2(strob2), .busy(busy)
    );

    pr_access_seq #(.SETUP_LEN(3), .STB_LEN(4), .HOLD_LEN(3)) dut2 (
        .__clk(clk), .clm_(clm_),
        .a_req(a_req), .a_wr(a_wr), .a_ph2(a_ph2), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack2),
        .b_req(b_req), .b_wr(b_wr), .b_ph2(b_ph2), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack2),
        .rdata(rdata2), .l(l), .w(w2), .ra(ra2), .rb(rb2), .rc(rc2), .w_r(w_r2), .as2(as22),
        .strob1(s12), .strob2(s22), .busy(busy2)
    );

    // ctl = {a_ack, b_ack, busy, strob1, strob2, as2, w_r}; addr = {rc, rb, ra}
    typedef struct {
        logic        a_req, a_wr, a_ph2;
        logic [2:0]  a_addr;
        logic [15:0] a_wdata;
        logic        b_req, b_wr, b_ph2;
        logic [2:0]  b_addr;
        logic [15:0] l;
        logic [6:0]  e_ctl;
        logic [2:0]  e_addr;
        logic [15:0] e_w;
        logic [15:0] e_rdata;
    } vec_t;

    function automatic logic [41:0] outs1();
        return {a_ack, b_ack, busy, strob1, strob2, as2, w_r, rc, rb, ra, w, rdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        clm_ = 1'b0;
        tick();
        tick();
        clm_ = 1'b1;
    endtask

    initial begin
        vec_t vecs[12];
        int   acks, n, stb, overlap, order_n;
        logic order[4];
        logic prev_ack, prev_idle;

        clm_ = 1'b0; a_req = 0; a_wr = 0; a_ph2 = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_wr = 0; b_ph2 = 0; b_addr = 0; b_wdata = 16'h7777; l = 0;

        vecs[0]  = '{1,1,0,3'd3,16'h1234, 0,0,0,3'd0,16'h0000, 7'b0010001, 3'd3, 16'h1234, 16'h0000};
        vecs[1]  = '{1,1,0,3'd3,16'h1234, 0,0,0,3'd0,16'h0000, 7'b0011001, 3'd3, 16'h1234, 16'h0000};
        vecs[2]  = '{1,1,0,3'd3,16'h1234, 0,0,0,3'd0,16'h0000, 7'b0011001, 3'd3, 16'h1234, 16'h0000};
        vecs[3]  = '{1,1,0,3'd3,16'h1234, 0,0,0,3'd0,16'h0000, 7'b0010001, 3'd3, 16'h1234, 16'h0000};
        vecs[4]  = '{1,1,0,3'd3,16'h1234, 0,0,0,3'd0,16'h0000, 7'b1010000, 3'd0, 16'h0000, 16'h0000};
        vecs[5]  = '{0,0,0,3'd0,16'h0000, 0,0,0,3'd0,16'h0000, 7'b0000000, 3'd0, 16'h0000, 16'h0000};
        vecs[6]  = '{0,0,0,3'd0,16'h0000, 1,0,1,3'd0,16'hBEEF, 7'b0010010, 3'd0, 16'h0000, 16'h0000};
        vecs[7]  = '{0,0,0,3'd0,16'h0000, 1,0,1,3'd0,16'hBEEF, 7'b0010110, 3'd0, 16'h0000, 16'h0000};
        vecs[8]  = '{0,0,0,3'd0,16'h0000, 1,0,1,3'd0,16'hBEEF, 7'b0010110, 3'd0, 16'h0000, 16'h0000};
        vecs[9]  = '{0,0,0,3'd0,16'h0000, 1,0,1,3'd0,16'hBEEF, 7'b0010010, 3'd0, 16'h0000, 16'h0000};
        vecs[10] = '{0,0,0,3'd0,16'h0000, 1,0,1,3'd0,16'hBEEF, 7'b0110000, 3'd0, 16'h0000, 16'hBEEF};
        vecs[11] = '{0,0,0,3'd0,16'h0000, 0,0,0,3'd0,16'hBEEF, 7'b0000000, 3'd0, 16'h0000, 16'hBEEF};

        do_reset();
        chk("reset_outs", 64'(outs1()), 64'h0);
        chk("reset_outs2", 64'({a_ack2, b_ack2, busy2, s12, s22, as22, w_r2, rc2, rb2, ra2, w2, rdata2}), 64'h0);

        // A write R3 then B read R0 with ph2, one row per clock
        for (int i = 0; i < 12; i++) begin
            a_req = vecs[i].a_req; a_wr = vecs[i].a_wr; a_ph2 = vecs[i].a_ph2;
            a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
            b_req = vecs[i].b_req; b_wr = vecs[i].b_wr; b_ph2 = vecs[i].b_ph2;
            b_addr = vecs[i].b_addr; l = vecs[i].l;
            tick();
            chk($sformatf("vec%0d", i), 64'(outs1()),
                64'({vecs[i].e_ctl, vecs[i].e_addr, vecs[i].e_w, vecs[i].e_rdata}));
        end

        // requester data changing mid-access must not reach W
        a_req = 1; a_wr = 1; a_ph2 = 0; a_addr = 3'd2; a_wdata = 16'h0001;
        tick();
        chk("wlatch_setup", 64'(w), 64'h0001);
        a_wdata = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("wlatch_c%0d", i), 64'(w), 64'h0001);
        end
        tick();
        chk("wlatch_ack", 64'({a_ack, b_ack}), 64'b10);
        a_req = 0;
        tick();

        // continuous contest: alternate grants, one dead cycle, no strobe overlap
        do_reset();
        a_req = 1; a_wr = 0; a_addr = 3'd1; b_req = 1; b_wr = 0; b_addr = 3'd2; l = 16'h0A0A;
        order_n = 0; overlap = 0; prev_ack = 0; prev_idle = 0;
        for (int c = 0; c < 60 && order_n < 4; c++) begin
            tick();
            if (strob1 && strob2) overlap++;
            if (prev_idle) chk("rr_setup_after_dead", 64'(busy), 64'h1);
            prev_idle = 0;
            if (prev_ack) begin
                chk("rr_dead_cycle", 64'(busy), 64'h0);
                prev_idle = 1;
            end
            prev_ack = a_ack | b_ack;
            if (a_ack | b_ack) begin
                order[order_n] = b_ack;
                order_n++;
            end
        end
        chk("rr_ack_count", 64'(order_n), 64'd4);
        chk("rr_order", 64'({order[0], order[1], order[2], order[3]}), 64'b0101);
        chk("rr_no_overlap", 64'(overlap), 64'h0);
        a_req = 0; b_req = 0;
        tick();

        // reset during the second strobe cycle aborts the access
        do_reset();
        a_req = 1; a_wr = 1; a_ph2 = 0; a_addr = 3'd5; a_wdata = 16'h0055;
        tick();
        tick();
        tick();
        chk("abort_pre_strobe", 64'(strob1), 64'h1);
        clm_ = 0; a_req = 0;
        tick();
        chk("abort_outs", 64'({outs1(), busy}), 64'h0);
        clm_ = 1;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (a_ack | b_ack) acks++;
        end
        chk("abort_no_ack", 64'(acks), 64'h0);
        a_req = 1; b_req = 1; b_wr = 0;
        n = 0;
        while (!(a_ack | b_ack) && n < 12) begin
            tick();
            n++;
        end
        chk("abort_next_grant_a", 64'({a_ack, b_ack}), 64'b10);
        a_req = 0; b_req = 0;
        tick();

        // longer timing build: 4-cycle strobe, ack on cycle 12
        do_reset();
        a_req = 1; a_wr = 0; a_ph2 = 0; a_addr = 3'd1;
        n = 0; stb = 0;
        while (!a_ack2 && n < 30) begin
            tick();
            n++;
            if (s12) stb++;
        end
        chk("long_ack_cycle", 64'(n + 1), 64'd12);
        chk("long_strobe_len", 64'(stb), 64'd4);
        a_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pr_access_seq.md
Name: pr_access_seq

Overview:
- Sequences every access to the P-R register file: R0 (flags) and user registers R1-R7.
- Arbitrates between two requesters, the control unit (port A) and the control panel (port B).
- For each granted request, drives address, W bus, w_r and the phased strobes (strob1/strob2 selected by as2) with fixed setup/strobe/hold timing.
- Returns L-bus read data with a one-cycle acknowledge. Sits between the control logic and the pr register unit.

Parameters:
- SETUP_LEN, 1, cycles address/W/w_r are stable before the strobe; legal range 1..3.
- STB_LEN, 2, cycles the strobe stays high; legal range 1..4.
- HOLD_LEN, 1, cycles address/W held after the strobe falls; L bus is sampled on the last hold cycle; legal range 1..3.

Ports:
- __clk  in  1  system clock.
- clm_  in  1  synchronous active-low reset, sampled on the rising edge of __clk.
- a_req  in  1  port A request; level, held until a_ack.
- a_wr  in  1  port A: 1 = write, 0 = read.
- a_ph2  in  1  port A: 1 = second-phase access (strob2, as2=1), 0 = strob1.
- a_addr  in  3  port A register number {rc,rb,ra}; 0 = R0.
- a_wdata  in  16  port A write data.
- a_ack  out  1  one-cycle completion pulse to port A.
- b_req, b_wr, b_ph2, b_addr[3], b_wdata[16], b_ack: same meanings for port B.
- rdata  out  16  read result; valid on the ack cycle, held until the next ack.
- l  in  16  L bus from the register unit.
- w  out  16  W bus to the register unit.
- ra, rb, rc  out  1 each  register address lines.
- w_r  out  1  write enable level.
- as2  out  1  phase select.
- strob1, strob2  out  1 each  strobes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (clm_=0 on a clock edge):
  - State returns to IDLE.
  - All outputs go to 0, including rdata=0, w=0 and both acks.
  - The round-robin pointer is set to A.
  - Reset during any state aborts the access immediately; no ack is issued and the strobe drops in the same cycle.
- States: IDLE -> SETUP -> STROBE -> HOLD -> ACK -> IDLE.
  - A 3-bit down-counter times SETUP, STROBE and HOLD. It is loaded with LEN-1 on entry to each state, and the state advances when the count is 0.
- IDLE:
  - If exactly one request is active, grant it.
  - If both are active, grant the port opposite the round-robin pointer's last grant, so the first contest after reset goes to A.
  - On grant, latch wr, ph2, addr and wdata into internal registers and enter SETUP. Later changes to the requester's inputs have no effect on the access in progress.
- SETUP:
  - ra/rb/rc = latched addr bits 0/1/2, i.e. ra = LSB.
  - as2 = latched ph2.
  - w = latched wdata if write, else 0.
  - w_r = latched wr.
- STROBE: the SETUP outputs are held. strob1=1 if ph2=0, or strob2=1 if ph2=1, for exactly STB_LEN cycles. Both strobes are never high together.
- HOLD:
  - Strobes are 0; the SETUP outputs are held for HOLD_LEN cycles.
  - On the last hold cycle, if the access is a read, rdata is loaded from l.
- ACK:
  - One cycle. The granted port's ack is 1; address, w and w_r return to 0.
  - The round-robin pointer records the granted port.
  - The next state is IDLE. No grant is made in this cycle, which guarantees one dead cycle between accesses.
- Latency: an access from grant to ack takes 1 (IDLE) + SETUP_LEN + STB_LEN + HOLD_LEN + 1 cycles. With defaults that is 6 cycles from the request being seen in IDLE to the ack.
- A requester must drop req on the cycle after its ack. A req still high in IDLE after that is treated as a new request.
- Reads of R0 with ph2=1 are legal; no special casing.
- busy=0 only in IDLE.

Decomposition:
- Shared package pr_pkg:
  - state enum: IDLE, SETUP, STROBE, HOLD, ACK.
  - localparam REG_R0 = 3'd0.
  - localparam for the counter width (3).
- One sub-module, pr_rr_arb: 2-input round-robin arbiter with grant/last-grant registers, reset by clm_.
- The timing FSM and datapath latches stay in pr_access_seq.

Test Plan:
- Reset, then A write (a_addr=3, a_wdata=16'h1234, ph2=0):
  - SETUP 1 cycle: rc=0, rb=1, ra=1, w=16'h1234, w_r=1.
  - strob1 high 2 cycles, strob2 stays 0.
  - a_ack pulses 6 cycles after request; rdata stays 0.
- B read, ph2=1, addr=0, with l=16'hBEEF:
  - as2=1, strob2 high 2 cycles, w_r=0, w=0.
  - b_ack pulses and rdata=16'hBEEF on the ack cycle.
- a_req and b_req asserted together continuously:
  - Grants alternate A, B, A, B.
  - Exactly one dead IDLE cycle between each ack and the next SETUP.
  - No overlapping strobes.
- clm_=0 pulsed during the 2nd STROBE cycle:
  - Next edge: strob1=0, all outputs 0, busy=0.
  - No ack is ever issued for the aborted access.
  - The next a_req after reset is granted to A.
- a_wdata changed from 16'h0001 to 16'hFFFF during STROBE: w stays 16'h0001 through HOLD.
- Rebuild with STB_LEN=4, SETUP_LEN=3, HOLD_LEN=3: strobe high exactly 4 cycles and ack at cycle 12.
